// File: rtl/sweep_pkg.sv
// sweep_pkg: shared widths and sequencer state encoding for the port-A sweep controller.
package sweep_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
endpackage

// File: rtl/sweep_adder.sv
// sweep_adder: word + increment; saturates at all-ones when SWEEP_SATURATE_EN is defined, else wraps.
module sweep_adder #(
  parameter int DATA_W = sweep_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
`ifdef SWEEP_SATURATE_EN
  logic [DATA_W:0] full;
  assign full = {1'b0, a} + {1'b0, b};
  assign sum = full[DATA_W] ? '1 : full[DATA_W-1:0];
`else
  assign sum = a + b;
`endif
endmodule

// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: port-A read-modify-write sweep over an inclusive, wrapping address range.
// Saturating add selected by SWEEP_SATURATE_EN (see sweep_adder).
module mem_sweep_ctrl #(
  parameter int ADDR_W = sweep_pkg::ADDR_W,
  parameter int DATA_W = sweep_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] increment,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_valid
);
  import sweep_pkg::*;
  state_t state, state_n;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] inc_q, sum;
  sweep_adder #(.DATA_W(DATA_W)) u_add (.a(mem_rdata), .b(inc_q), .sum(sum));
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RD : IDLE;
      RD:      state_n = CAP;
      CAP:     state_n = WR;
      WR:      state_n = (mem_addr == last_q) ? DONE : RD;
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state == RD) || (state == CAP) || (state == WR);
  assign done = state == DONE;
  // mem_addr doubles as the sweep cursor; it wraps naturally at ADDR_W bits.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
      last_q     <= '0;
      inc_q      <= '0;
    end else begin
      mem_we     <= state == CAP;
      disp_valid <= state == CAP;
      if (state == IDLE && start) begin
        mem_addr <= first_addr;
        last_q   <= last_addr;
        inc_q    <= increment;
      end
      if (state == CAP) begin
        mem_wdata  <= sum;
        disp_value <= sum;
      end
      if (state == WR && mem_addr != last_q) mem_addr <= mem_addr + 1'b1;
    end
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: directed scenarios against a 1024x16 one-cycle-latency memory model.
module tb_mem_sweep_ctrl;
  logic clock = 0, reset = 1, start = 0;
  logic [9:0] first_addr = 0, last_addr = 0;
  logic [15:0] increment = 0;
  logic busy, done, mem_we, disp_valid;
  logic [9:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, disp_value;
  logic [15:0] mem [1024];
  logic pre_we = 0;
  logic [9:0] pre_addr = 0;
  logic [15:0] pre_data = 0;
  logic [9:0] wr_log[$];
  logic [15:0] dvals[$];
  int nbusy, done_c, chk_cnt = 0, pass_cnt = 0;

  mem_sweep_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .increment(increment), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .disp_value(disp_value), .disp_valid(disp_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_log.push_back(mem_addr);
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    @(negedge clock);
    pre_we = 1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 0;
  endtask

  task automatic sweep(input logic [9:0] f, input logic [9:0] l, input logic [15:0] inc, input int poke);
    @(negedge clock);
    first_addr = f; last_addr = l; increment = inc; start = 1;
    nbusy = 0; done_c = 0;
    dvals.delete(); wr_log.delete();
    for (int c = 1; c <= 4000 && done_c == 0; c++) begin
      @(negedge clock);
      start = (c == poke);
      if (busy) nbusy++;
      if (done) done_c = c;
      if (disp_valid) dvals.push_back(disp_value);
    end
    chk_cnt++;
    if (done_c == 0) $display("FAIL sweep_timeout: done never seen, required within 4000 cycles");
    else pass_cnt++;
    start = 0;
    @(negedge clock);
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_width: done=%b busy=%b, required 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    #2;
    chk_cnt++;
    if ({busy, done, mem_we, disp_valid} !== 4'b0) $display("FAIL reset_flags: busy/done/we/dv=%b required 0000", {busy, done, mem_we, disp_valid});
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 10'd0 || mem_wdata !== 16'd0 || disp_value !== 16'd0)
      $display("FAIL reset_data: addr=%0d wdata=%h disp=%h required 0 0 0", mem_addr, mem_wdata, disp_value);
    else pass_cnt++;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_basic;
    logic [15:0] e[3] = '{16'd16, 16'd17, 16'd18};
    load(0, 1); load(1, 2); load(2, 3);
    sweep(0, 2, 15, 0);
    chk_cnt++;
    if (nbusy != 9) $display("FAIL basic_busy: %0d cycles, required 9", nbusy); else pass_cnt++;
    chk_cnt++;
    if (done_c != 10) $display("FAIL basic_done: cycle %0d, required 10", done_c); else pass_cnt++;
    chk_cnt++;
    if (dvals.size() != 3) $display("FAIL basic_dv_count: %0d, required 3", dvals.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (mem[i] !== e[i]) $display("FAIL basic_mem%0d: %0d, required %0d", i, mem[i], e[i]); else pass_cnt++;
      chk_cnt++;
      if (dvals.size() <= i || dvals[i] !== e[i]) $display("FAIL basic_disp%0d: wrong or missing, required %0d", i, e[i]); else pass_cnt++;
    end
    chk_cnt++;
    if (disp_value !== 16'd18) $display("FAIL basic_disp_hold: %0d, required 18", disp_value); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [9:0] ea[4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    logic [15:0] ev[4] = '{16'd101, 16'd201, 16'd301, 16'd401};
    load(1022, 100); load(1023, 200); load(0, 300); load(1, 400); load(2, 555);
    sweep(1022, 1, 1, 0);
    chk_cnt++;
    if (nbusy != 12) $display("FAIL wrap_busy: %0d cycles, required 12", nbusy); else pass_cnt++;
    chk_cnt++;
    if (wr_log.size() != 4) $display("FAIL wrap_count: %0d writes, required 4", wr_log.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (wr_log.size() <= i || wr_log[i] !== ea[i]) $display("FAIL wrap_order%0d: wrong or missing, required addr %0d", i, ea[i]); else pass_cnt++;
      chk_cnt++;
      if (mem[ea[i]] !== ev[i]) $display("FAIL wrap_mem%0d: %0d, required %0d", ea[i], mem[ea[i]], ev[i]); else pass_cnt++;
    end
    chk_cnt++;
    if (mem[2] !== 16'd555) $display("FAIL wrap_untouched: %0d, required 555", mem[2]); else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [15:0] exp;
`ifdef SWEEP_SATURATE_EN
    exp = 16'hFFFF;
`else
    exp = 16'h0004;
`endif
    load(0, 16'hFFF5);
    sweep(0, 0, 15, 0);
    chk_cnt++;
    if (mem[0] !== exp) $display("FAIL overflow: %h, required %h", mem[0], exp); else pass_cnt++;
  endtask

  task automatic test_start_during_busy;
    load(10, 5); load(11, 6);
    sweep(10, 11, 1, 4);
    chk_cnt++;
    if (nbusy != 6) $display("FAIL poke_busy: %0d cycles, required 6", nbusy); else pass_cnt++;
    chk_cnt++;
    if (mem[10] !== 16'd6 || mem[11] !== 16'd7) $display("FAIL poke_mem: %0d %0d, required 6 7", mem[10], mem[11]); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk_cnt++;
      if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL poke_no_rerun: busy=%b we=%b, required 0 0", busy, mem_we); else pass_cnt++;
    end
    chk_cnt++;
    if (wr_log.size() != 2) $display("FAIL poke_writes: %0d, required 2", wr_log.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] bseq, dseq;
    load(20, 1);
    @(negedge clock);
    first_addr = 20; last_addr = 20; increment = 2; start = 1;
    wr_log.delete();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      bseq[c] = busy;
      dseq[c] = done;
      if (c == 6) begin
        chk_cnt++;
        if (mem_addr !== 10'd20 || mem_we !== 1'b0) $display("FAIL b2b_rd: addr=%0d we=%b, required 20 0", mem_addr, mem_we); else pass_cnt++;
      end
      if (c == 9) start = 0;
    end
    chk_cnt++;
    if (bseq[9:1] !== 9'b011100111) $display("FAIL b2b_busy: %b, required 011100111 (cycle 9..1)", bseq[9:1]); else pass_cnt++;
    chk_cnt++;
    if (dseq[9:1] !== 9'b100001000) $display("FAIL b2b_done: %b, required 100001000 (cycle 9..1)", dseq[9:1]); else pass_cnt++;
    repeat (3) @(negedge clock);
    chk_cnt++;
    if (mem[20] !== 16'd5 || wr_log.size() != 2) $display("FAIL b2b_mem: %0d after %0d writes, required 5 after 2", mem[20], wr_log.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int seen_done;
    load(30, 10); load(31, 20); load(32, 30); load(33, 40);
    @(negedge clock);
    first_addr = 30; last_addr = 33; increment = 1; start = 1;
    wr_log.delete();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      start = 0;
    end
    chk_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd31) $display("FAIL mid_in_wr: we=%b addr=%0d, required 1 31", mem_we, mem_addr); else pass_cnt++;
    reset = 1;
    #1;
    chk_cnt++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || disp_valid !== 1'b0 || mem_addr !== 10'd0)
      $display("FAIL mid_async: we=%b busy=%b dv=%b addr=%0d, required 0 0 0 0", mem_we, busy, disp_valid, mem_addr);
    else pass_cnt++;
    @(negedge clock);
    reset = 0;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (done) seen_done = 1;
    end
    chk_cnt++;
    if (seen_done != 0) $display("FAIL mid_no_done: done pulsed, required none"); else pass_cnt++;
    chk_cnt++;
    if ({mem[30], mem[31], mem[32], mem[33]} !== {16'd11, 16'd20, 16'd30, 16'd40})
      $display("FAIL mid_mem: %0d %0d %0d %0d, required 11 20 30 40", mem[30], mem[31], mem[32], mem[33]);
    else pass_cnt++;
    sweep(32, 33, 1, 0);
    chk_cnt++;
    if (nbusy != 6 || done_c != 7) $display("FAIL mid_resweep: busy=%0d done=%0d, required 6 7", nbusy, done_c); else pass_cnt++;
    chk_cnt++;
    if (mem[32] !== 16'd31 || mem[33] !== 16'd41) $display("FAIL mid_resweep_mem: %0d %0d, required 31 41", mem[32], mem[33]); else pass_cnt++;
  endtask

  task automatic test_single;
    load(513, 7);
    sweep(513, 513, 7, 0);
    chk_cnt++;
    if (mem[513] !== 16'd14) $display("FAIL single_mem: %0d, required 14", mem[513]); else pass_cnt++;
    chk_cnt++;
    if (nbusy != 3 || done_c != 4) $display("FAIL single_timing: busy=%0d done=%0d, required 3 4", nbusy, done_c); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_overflow;
    test_start_during_busy;
    test_back_to_back;
    test_reset_mid;
    test_single;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_sweep_ctrl.md
# mem_sweep_ctrl

Port-A sequencer for the 1024 x 16 DualPortMemory. On a start request it sweeps a latched address range, performing a read-modify-write on each word (add a programmable increment), and publishes each updated word on a display bus for the hexTo7Seg digit stage. It sits directly upstream of the memory and replaces hand-stepped, button-clocked port-A control with a single-clock sequencer that honours the memory's one-cycle read latency.

## Interface
- ADDR_W, 10, memory address width (1024 words)
- DATA_W, 16, memory word width
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  sweep request; sampled only in IDLE
- first_addr  in  ADDR_W  first address of sweep; latched on accepted start
- last_addr  in  ADDR_W  last address of sweep, inclusive; latched on accepted start
- increment  in  DATA_W  value added to each word; latched on accepted start
- busy  out  1  high from the cycle after start is accepted until the last write cycle, inclusive
- done  out  1  one-cycle pulse in the cycle after the last write
- mem_addr  out  ADDR_W  to memory addr_a; registered
- mem_we  out  1  to memory we_a; registered
- mem_wdata  out  DATA_W  to memory data_a; registered
- mem_rdata  in  DATA_W  from memory q_a
- disp_value  out  DATA_W  most recently written word; feeds the four hexTo7Seg digits
- disp_valid  out  1  one-cycle pulse when disp_value updates

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: busy=0, mem_we=0. If start=1: latch first_addr, last_addr, increment; set cur=first_addr; go to RD.
- RD: mem_addr=cur, mem_we=0; go to CAP.
- CAP: mem_rdata holds word[cur]; compute sum = mem_rdata + increment; load mem_wdata=sum, disp_value=sum; pulse disp_valid; go to WR.
- WR: mem_we=1, mem_addr=cur, mem_wdata=sum. If cur==last_addr, go to DONE. Otherwise cur=cur+1 mod 2^ADDR_W and go to RD.
- DONE: done=1 for one cycle, busy=0; return to IDLE.
- Wrap-around: if last_addr < first_addr, the sweep runs through 1023 to 0 and stops at last_addr. Word count N = ((last-first) mod 1024)+1. first==last gives exactly one word; a full 1024-word sweep is not expressible.
- Arithmetic: the sum is truncated to DATA_W (modulo 2^16) unless the macro below is defined.
- start while busy or in DONE: ignored; no queueing. start held high: a new sweep begins on the IDLE cycle following DONE.
- Port B is untouched by this block; downstream readers own it.

## Timing
- Accepted start at edge k: RD is active in cycle k+1. Each word takes 3 cycles (RD, CAP, WR), so busy is high for 3N cycles. done is high in cycle 3N+1 after acceptance, and the next start can be accepted in cycle 3N+2.
- Memory read latency is 1 cycle: the address presented in RD is valid as mem_rdata in CAP.
- The write commits at the rising edge that ends WR.
- Reset values: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_value=0, disp_valid=0.
- Reset mid-sweep: all outputs return to their reset values asynchronously. mem_we drops before the next edge, so the current word is either fully written or untouched. Remaining words stay unmodified, and no done pulse is produced.

## Configuration
- SWEEP_SATURATE_EN defined: if mem_rdata + increment > 2^DATA_W-1, the written value is 16'hFFFF.
- SWEEP_SATURATE_EN undefined: the sum wraps modulo 2^DATA_W.

## Structure
- Shared package sweep_pkg holds the state enum (IDLE, RD, CAP, WR, DONE) and the ADDR_W and DATA_W default constants, which are shared with the memory wrapper.
- One sub-module, sweep_adder: combinational add of mem_rdata and increment, with a saturate/wrap selection under SWEEP_SATURATE_EN. Everything else stays in mem_sweep_ctrl.

## Test plan
- Basic sweep: memory 0,1,2 = 1,2,3; start with first=0, last=2, increment=15 -> memory holds 16,17,18; busy high 9 cycles; done pulses in cycle 10; disp_value takes 16, 17, 18 with three disp_valid pulses.
- Wrap: first=1022, last=1, increment=1 -> writes occur in order 1022, 1023, 0, 1; busy high 12 cycles; address 2 unchanged.
- Overflow: word 0 = 16'hFFF5, increment=15 -> 16'h0004 without SWEEP_SATURATE_EN, 16'hFFFF with it.
- start pulsed during busy -> ignored, no extra writes; start held high -> back-to-back sweeps with exactly one IDLE cycle between DONE and the next RD.
- Reset asserted during WR of the second word -> mem_we=0 immediately; busy=0, done never pulses; the first word is updated and words after the second are unchanged; a subsequent start sweeps normally.
- Single word: first=last=513, increment=7, word=7 -> memory[513]=14; busy high 3 cycles; done in cycle 4.
